// File: rtl/fpu_addsub_mc.sv
// Multi-cycle IEEE-754 single add/sub (RTZ, FTZ), one op in flight, feeds float regfile write-back.
// Latency: 5 edges from start capture to done pulse; result/wa_out hold until next PACK.
// Backpressure: none; start is only sampled in IDLE (including the done cycle), ignored while busy.
module fpu_addsub_mc #(
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  wa_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  wa_out
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_PACK   = 3'd5;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    logic [2:0]  state;
    logic [31:0] a_r, b_r;
    logic        op_r;
    logic [4:0]  wa_r;
    logic        up_sa, up_sb, spec;
    logic [7:0]  up_ea, up_eb;
    logic [23:0] up_ma, up_mb;
    logic [31:0] spec_val;
    logic        al_sl, al_ss;
    logic [7:0]  al_exp;
    logic [26:0] al_ml, al_ms;
    logic [27:0] ad_sum;
    logic        ad_sign;
    logic [7:0]  ad_exp;
    logic               nm_sign, nm_zero;
    logic signed [9:0]  nm_exp;
    logic [22:0]        nm_frac;

    // Unpack: effective sign of B, flush denormals, classify specials
    logic        u_sa, u_sb, u_spec;
    logic [7:0]  u_ea, u_eb;
    logic [23:0] u_ma, u_mb;
    logic [31:0] u_spec_val;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    always_comb begin
        u_sa = a_r[31];
        u_sb = b_r[31] ^ op_r;
        u_ea = a_r[30:23];
        u_eb = b_r[30:23];
        zero_a = (u_ea == 8'd0);
        zero_b = (u_eb == 8'd0);
        u_ma = zero_a ? 24'd0 : {1'b1, a_r[22:0]};
        u_mb = zero_b ? 24'd0 : {1'b1, b_r[22:0]};
        nan_a = (u_ea == 8'hFF) && (a_r[22:0] != 23'd0);
        nan_b = (u_eb == 8'hFF) && (b_r[22:0] != 23'd0);
        inf_a = (u_ea == 8'hFF) && (a_r[22:0] == 23'd0);
        inf_b = (u_eb == 8'hFF) && (b_r[22:0] == 23'd0);
        u_spec = 1'b1;
        u_spec_val = 32'd0;
        if (nan_a || nan_b)                     u_spec_val = QNAN;
        else if (inf_a && inf_b && u_sa != u_sb) u_spec_val = QNAN;
        else if (inf_a)                         u_spec_val = {u_sa, 31'h7F80_0000};
        else if (inf_b)                         u_spec_val = {u_sb, 31'h7F80_0000};
        else if (zero_a && zero_b)              u_spec_val = {u_sa & u_sb, 31'd0};
        else if (zero_a)                        u_spec_val = {u_sb, b_r[30:0]};
        else if (zero_b)                        u_spec_val = a_r;
        else                                    u_spec = 1'b0;
    end

    // Align: larger magnitude first, shift smaller right keeping a sticky bit
    logic        a_big;
    logic [7:0]  l_exp, s_exp, diff;
    logic [23:0] l_m, s_m;
    logic [26:0] s_ext, s_shift, s_mask, s_aligned;
    always_comb begin
        a_big = (up_ea > up_eb) || ((up_ea == up_eb) && (up_ma >= up_mb));
        l_exp = a_big ? up_ea : up_eb;
        s_exp = a_big ? up_eb : up_ea;
        l_m   = a_big ? up_ma : up_mb;
        s_m   = a_big ? up_mb : up_ma;
        diff  = l_exp - s_exp;
        s_ext = {s_m, 3'b000};
        s_shift = s_ext >> diff;
        s_mask  = (27'd1 << diff) - 27'd1;
        if (diff >= 8'd27)
            s_aligned = {26'd0, |s_ext};
        else
            s_aligned = {s_shift[26:1], s_shift[0] | (|(s_ext & s_mask))};
    end

    // Normalize: single-cycle leading-zero count over the 27-bit magnitude
    logic [4:0]        lz;
    logic [26:0]       n_mant;
    logic signed [9:0] n_exp;
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (ad_sum[i]) lz = 5'(26 - i);
        if (ad_sum[27]) begin
            n_mant = {ad_sum[27:2], ad_sum[1] | ad_sum[0]};
            n_exp  = $signed({2'b00, ad_exp}) + 10'sd1;
        end else begin
            n_mant = ad_sum[26:0] << lz;
            n_exp  = $signed({2'b00, ad_exp}) - $signed({5'd0, lz});
        end
    end

    // Round-toward-zero drops the hidden bit and GRS; overflow saturates to inf on purpose
    logic [31:0] pk_val;
    always_comb begin
        if (spec)                    pk_val = spec_val;
        else if (nm_zero)            pk_val = 32'd0;
        else if (nm_exp >= 10'sd255) pk_val = {nm_sign, 31'h7F80_0000};
        else if (nm_exp <= 10'sd0)   pk_val = {nm_sign, 31'd0};
        else                         pk_val = {nm_sign, nm_exp[7:0], nm_frac};
    end

    logic unused_bits;
    assign unused_bits = ^{n_mant[26], n_mant[2:0], (LATENCY == 5)};

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            done <= 1'b0; result <= 32'd0; wa_out <= 5'd0;
            a_r <= 32'd0; b_r <= 32'd0; op_r <= 1'b0; wa_r <= 5'd0;
            up_sa <= 1'b0; up_sb <= 1'b0; up_ea <= 8'd0; up_eb <= 8'd0;
            up_ma <= 24'd0; up_mb <= 24'd0; spec <= 1'b0; spec_val <= 32'd0;
            al_sl <= 1'b0; al_ss <= 1'b0; al_exp <= 8'd0; al_ml <= 27'd0; al_ms <= 27'd0;
            ad_sum <= 28'd0; ad_sign <= 1'b0; ad_exp <= 8'd0;
            nm_sign <= 1'b0; nm_zero <= 1'b0; nm_exp <= 10'sd0; nm_frac <= 23'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    a_r <= a; b_r <= b; op_r <= op; wa_r <= wa_in;
                    state <= S_UNPACK;
                end
                S_UNPACK: begin
                    up_sa <= u_sa; up_sb <= u_sb; up_ea <= u_ea; up_eb <= u_eb;
                    up_ma <= u_ma; up_mb <= u_mb; spec <= u_spec; spec_val <= u_spec_val;
                    state <= S_ALIGN;
                end
                S_ALIGN: begin
                    al_sl  <= a_big ? up_sa : up_sb;
                    al_ss  <= a_big ? up_sb : up_sa;
                    al_exp <= l_exp;
                    al_ml  <= {l_m, 3'b000};
                    al_ms  <= s_aligned;
                    state  <= S_ADD;
                end
                S_ADD: begin
                    ad_sum  <= (al_sl == al_ss) ? ({1'b0, al_ml} + {1'b0, al_ms})
                                                : ({1'b0, al_ml} - {1'b0, al_ms});
                    ad_sign <= al_sl;
                    ad_exp  <= al_exp;
                    state   <= S_NORM;
                end
                S_NORM: begin
                    nm_sign <= ad_sign;
                    nm_zero <= (ad_sum == 28'd0);
                    nm_exp  <= n_exp;
                    nm_frac <= n_mant[25:3];
                    state   <= S_PACK;
                end
                S_PACK: begin
                    result <= pk_val;
                    wa_out <= wa_r;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_mc.sv
// Directed bench for fpu_addsub_mc: arithmetic vectors, specials, handshake timing, async reset.
module tb_fpu_addsub_mc;
    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [31:0] a, b, result;
    logic [4:0]  wa_in, wa_out;
    logic        busy, done;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fpu_addsub_mc dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wa_in(wa_in), .busy(busy), .done(done), .result(result), .wa_out(wa_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] w, input logic [31:0] exp);
        start = 1'b1; op = o; a = x; b = y; wa_in = w;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_res"}, result, exp);
        check({tag, "_wa"}, 32'(wa_out), 32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        int first_at, second_at;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0; wa_in = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_wa", 32'(wa_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add_1_2", 1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd5, 32'h4040_0000);
        @(negedge clk);
        check("done_clears", 32'(done), 32'd0);
        check("hold_res", result, 32'h4040_0000);
        // The following calls start in the done cycle: back-to-back issue.
        run_op("sub_lz2", 1'b1, 32'h3F80_0000, 32'h3F40_0000, 5'd1, 32'h3E80_0000);
        run_op("sub_zero", 1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 5'd2, 32'h0000_0000);
        run_op("sub_sticky", 1'b1, 32'h3F80_0000, 32'h3080_0000, 5'd3, 32'h3F7F_FFFF);
        run_op("add_trunc", 1'b0, 32'h3F80_0000, 32'h3080_0000, 5'd4, 32'h3F80_0000);
        run_op("inf_m_inf", 1'b1, 32'h7F80_0000, 32'h7F80_0000, 5'd6, 32'h7FC0_0000);
        run_op("ovf_inf", 1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd7, 32'h7F80_0000);
        run_op("nan_in", 1'b0, 32'h7FC0_0001, 32'h0000_0000, 5'd8, 32'h7FC0_0000);
        run_op("denorm_z", 1'b0, 32'h0000_0001, 32'h8000_0000, 5'd9, 32'h0000_0000);
        run_op("neg_sum", 1'b1, 32'hBF80_0000, 32'h4000_0000, 5'd10, 32'hC040_0000);
        run_op("one_zero", 1'b1, 32'h0000_0000, 32'h4000_0000, 5'd11, 32'hC000_0000);
        run_op("inf_fin", 1'b1, 32'h3F80_0000, 32'h7F80_0000, 5'd12, 32'hFF80_0000);
        @(negedge clk);

        // start held high: captures only in IDLE / done cycles
        start = 1'b1; op = 1'b0; a = 32'h3F80_0000; b = 32'h4000_0000; wa_in = 5'd7;
        ndone = 0; first_at = 0; second_at = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_at = i;
                    check("held_res1", result, 32'h4040_0000);
                    check("held_wa1", 32'(wa_out), 32'd7);
                end else if (ndone == 2) begin
                    second_at = i;
                    check("held_res2", result, 32'h3E80_0000);
                    check("held_wa2", 32'(wa_out), 32'd9);
                end
            end
            if (i == 3) begin
                op = 1'b1; a = 32'h3F80_0000; b = 32'h3F40_0000; wa_in = 5'd9;
            end
            if (i == 7) start = 1'b0;
        end
        check("held_ndone", 32'(ndone), 32'd2);
        check("held_first", 32'(first_at), 32'd6);
        check("held_second", 32'(second_at), 32'd12);

        // async reset pulsed while the op sits in ADD
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h3F80_0000; b = 32'h4000_0000; wa_in = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_res", result, 32'd0);
        check("arst_wa", 32'(wa_out), 32'd0);
        #3 reset = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_nodone", 32'(ndone), 32'd0);
        run_op("post_rst", 1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd21, 32'h4040_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_addsub_mc.md
Name: fpu_addsub_mc

Overview:
- Multi-cycle IEEE-754 single-precision add/subtract unit.
- Sits directly upstream of regfile_float: consumes its rd1/rd2 read data and produces the write-back word.
- Its done/wa_out/result outputs drive regwrite_float/wa3/wd3.
- One operation in flight at a time; fixed latency; start/busy/done handshake with the control unit.

Parameters:
- LATENCY, 5, edges from the start-sampling edge to done assertion. Fixed by the FSM; informational only, must not be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = a+b, 1 = a-b.
- a  input  32  operand A (regfile_float rd1).
- b  input  32  operand B (regfile_float rd2).
- wa_in  input  5  destination float register.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; result and wa_out valid; drives regwrite_float.
- result  output  32  IEEE-754 single result (wd3).
- wa_out  output  5  captured destination (wa3).

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; result=0; wa_out=0; in-flight op discarded with no done pulse.
- FSM states: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> PACK -> IDLE. Each non-IDLE state lasts exactly one cycle.
- IDLE: on an edge with start=1, register a, b, op, wa_in; go to UNPACK. start=1 outside IDLE is ignored.
- Timing: capture at edge k; PACK->IDLE at edge k+5 registers result/wa_out and sets done=1. done clears at edge k+6.
- busy=1 after edges k..k+4, i.e. 5 cycles. busy=0 during the done cycle, so a new start may be sampled in that cycle (back-to-back issue).
- result/wa_out hold their values until the next PACK or reset.
- UNPACK: effective B sign = b[31]^op.
  - Exponent 0 (zero/denormal) is flushed to signed zero.
  - Hidden bit 1 is prepended for normals.
  - Special-case flag and value are computed here.
- Special cases (bypass the datapath; latency unchanged):
  - Any NaN input -> 0x7FC00000.
  - inf - inf (effective) -> 0x7FC00000.
  - inf op finite -> that inf.
  - Both zero -> sign = sA & sB_eff.
  - One zero -> the other operand (B with effective sign).
- ALIGN: swap so |A| >= |B| by exponent, then mantissa.
  - Mantissa is 27 bits: hidden + 23 + guard, round, sticky.
  - Right-shift B by the exponent difference; sticky = OR of shifted-out bits.
  - Difference >= 27: B becomes sticky-only (0...01 if nonzero).
- ADD: 28-bit add (same effective sign) or subtract (larger - smaller). Result sign = sign of the larger operand.
- NORM:
  - Carry out: shift right 1, fold sticky, exponent +1.
  - Otherwise: left-shift by leading-zero count (single-cycle priority encoder), exponent -= count.
  - Exact zero magnitude -> +0 (0x00000000).
- PACK: rounding is round-toward-zero (truncate GRS).
  - Exponent >= 255 -> signed inf (0x7F800000 | sign). This overflow behaviour is a deliberate deviation from IEEE RTZ.
  - Exponent <= 0 -> signed zero.
- No exception flags.

Test Plan:
- reset; start, op=0, a=0x3F800000, b=0x40000000, wa_in=5 -> busy 5 cycles; done 1 cycle 5 edges after capture; result=0x40400000; wa_out=5.
- op=1, a=0x3F800000, b=0x3F400000 -> result=0x3E800000 (normalize left by 2). op=1, a=b=0x3FC00000 -> 0x00000000.
- op=1, a=0x3F800000, b=0x30800000 (2^-30) -> 0x3F7FFFFF (sticky + truncate). op=0, same operands -> 0x3F800000.
- Specials:
  - op=1, a=b=0x7F800000 -> 0x7FC00000.
  - op=0, a=0x7F7FFFFF, b=0x7F7FFFFF -> 0x7F800000.
  - op=0, a=0x7FC00001, b=0 -> 0x7FC00000.
  - op=0, a=0x00000001 (denormal), b=0x80000000 -> 0x00000000.
- Handshake:
  - start held high throughout -> new op captured only in IDLE/done cycles, none while busy.
  - Second start asserted in the done cycle -> next done exactly 5 edges later.
- Async reset pulsed while in ADD -> busy/done/result/wa_out go 0 immediately (no clock edge); no done pulse follows; next start behaves normally.
